// File: rtl/riscv_multicycle.sv
// Multicycle RV32I subset core (lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal)
// with one unified memory port using a req/ready handshake.
module riscv_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          REGS     = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Adr,
    output logic        MemReq,
    output logic        MemWrite,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData,
    input  logic        MemReady,
    output logic        Trap,
    output logic [3:0]  dbg_state
);

    // Memory handshake: a request is held (Adr/MemWrite/WriteData stable) while MemReq=1,
    // and completes on the first rising edge where MemReq and MemReady are both 1.
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam int         AW        = $clog2(REGS);

    state_t      state, state_next;
    logic        run;
    logic [31:0] pc, old_pc, instr, a, b, alu_out, data;
    logic [31:0] regs [REGS];
    logic [31:0] rs1_val, rs2_val, src_b, alu_res, rf_wdata;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic        rf_we, fire, is_sub;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign fire   = MemReq && MemReady;

    // Indices 0 and beyond the implemented depth read as zero.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0 && {27'b0, rs1} < 32'(REGS)) rs1_val = regs[rs1[AW-1:0]];
        if (rs2 != 5'd0 && {27'b0, rs2} < 32'(REGS)) rs2_val = regs[rs2[AW-1:0]];
    end

    always_comb begin
        src_b  = (state == S_EXECI) ? imm_i : b;
        is_sub = (state == S_EXECR) && instr[30];
        unique case (funct3)
            3'b000:  alu_res = is_sub ? (a - src_b) : (a + src_b);
            3'b010:  alu_res = {31'b0, $signed(a) < $signed(src_b)};
            3'b110:  alu_res = a | src_b;
            3'b111:  alu_res = a & src_b;
            default: alu_res = a + src_b;
        endcase
    end

    // run holds MemReq low for the first cycle after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH:    if (fire) state_next = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (fire) state_next = S_MEMWB;
            S_MEMWRITE: if (fire) state_next = S_FETCH;
            S_EXECR, S_EXECI: state_next = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ, S_JAL: state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        MemReq   = 1'b0;
        MemWrite = 1'b0;
        Adr      = alu_out;
        rf_we    = 1'b0;
        rf_wdata = alu_out;
        unique case (state)
            S_FETCH: begin
                MemReq = run;
                Adr    = pc;
            end
            S_MEMREAD:  MemReq = run;
            S_MEMWRITE: begin
                MemReq   = run;
                MemWrite = run;
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wdata = data;
            end
            S_ALUWB: rf_we = 1'b1;
            S_JAL: begin
                rf_we    = 1'b1;
                rf_wdata = pc;
            end
            default: ;
        endcase
    end

    assign WriteData = b;
    assign Trap      = (state == S_TRAP);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            if (state == S_FETCH && fire) pc <= pc + 32'd4;
            else if (state == S_BEQ && a == b) pc <= alu_out;
            else if (state == S_JAL) pc <= old_pc + imm_j;
        end
    end

    // Datapath latches are intentionally not reset; their enables are idle in reset.
    always_ff @(posedge clk) begin
        unique case (state)
            S_FETCH: if (fire) begin
                instr  <= ReadData;
                old_pc <= pc;
            end
            S_DECODE: begin
                a       <= rs1_val;
                b       <= rs2_val;
                alu_out <= old_pc + imm_b;
            end
            S_MEMADR:  alu_out <= a + ((opcode == OP_STORE) ? imm_s : imm_i);
            S_MEMREAD: if (fire) data <= ReadData;
            S_EXECR, S_EXECI: alu_out <= alu_res;
            default: ;
        endcase
        if (rf_we && rd != 5'd0 && {27'b0, rd} < 32'(REGS)) regs[rd[AW-1:0]] <= rf_wdata;
    end

endmodule

// File: tb/tb_riscv_multicycle.sv
// Directed bench for riscv_multicycle: small programs in a wait-state memory model,
// with store scoreboard, fetch trace and cycle-count checks.
module tb_riscv_multicycle;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Adr, WriteData;
    logic        MemReq, MemWrite, Trap;
    logic [31:0] ReadData = 32'h0;
    logic        MemReady = 1'b0;
    logic [3:0]  dbg_state;

    riscv_multicycle dut (
        .clk(clk), .reset(reset), .Adr(Adr), .MemReq(MemReq), .MemWrite(MemWrite),
        .WriteData(WriteData), .ReadData(ReadData), .MemReady(MemReady), .Trap(Trap),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [256];
    logic [63:0] exp_q [$];
    logic [31:0] fa_q [$];
    int          fc_q [$];
    int          cyc = 0, fetch_wait = 0, data_wait = 0, wait_left = 0, held40 = 0;
    logic        idle_ready = 1'b0;
    logic        p_req = 1'b0, p_rdy = 1'b0, p_we = 1'b0, p_fetch = 1'b0;
    logic [31:0] p_adr = 32'h0, p_wd = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[9:2]] = word;
    endtask

    // Memory model: decides MemReady each cycle, applies completed stores, logs fetches.
    always @(negedge clk) begin
        logic [63:0] e;
        cyc = cyc + 1;
        if (!reset) begin
            MemReady  = 1'b0;
            p_req     = 1'b0;
            p_rdy     = 1'b0;
            wait_left = 0;
        end else begin
            if (p_req && p_rdy) begin
                if (p_we) begin
                    mem[p_adr[9:2]] = p_wd;
                    if (exp_q.size() == 0) begin
                        check("store_unexpected", p_adr, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("store_adr", p_adr, e[63:32]);
                        check("store_data", p_wd, e[31:0]);
                    end
                end else if (p_fetch) begin
                    fa_q.push_back(p_adr);
                    fc_q.push_back(cyc);
                end
            end
            if (p_req && !p_rdy && MemReq) begin
                check("hold_adr", Adr, p_adr);
                check("hold_we", {31'b0, MemWrite}, {31'b0, p_we});
                if (p_we) check("hold_wd", WriteData, p_wd);
            end
            if (MemReq && MemWrite && Adr == 32'h40 && WriteData == 32'd12) held40++;
            if (MemReq) begin
                if (!(p_req && !p_rdy)) wait_left = (dbg_state == 4'd0) ? fetch_wait : data_wait;
                if (wait_left > 0) begin
                    MemReady  = 1'b0;
                    wait_left = wait_left - 1;
                end else begin
                    MemReady = 1'b1;
                    ReadData = mem[Adr[9:2]];
                end
            end else begin
                MemReady = idle_ready;
                ReadData = 32'hDEAD_BEEF;
            end
            p_req = MemReq; p_rdy = MemReady; p_we = MemWrite;
            p_adr = Adr; p_wd = WriteData; p_fetch = (dbg_state == 4'd0);
        end
    end

    task automatic start_run();
        reset = 1'b0;
        fa_q.delete();
        fc_q.delete();
        exp_q.delete();
        held40 = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic wait_fetches(input int n, input int budget);
        int k = 0;
        while (fa_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("fetch_count", 32'(fa_q.size() >= n), 32'd1);
    endtask

    initial begin
        int k;
        int reqs;
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int reqs;

        // Run A: ALU sequence, stalled store, stalled load.
        start_run();
        fetch_wait = 0; data_wait = 3; idle_ready = 1'b1;
        put(32'h00, enc_i(OP_I, 5'd1, 3'b000, 5'd0, 12'd5));
        put(32'h04, enc_i(OP_I, 5'd2, 3'b000, 5'd0, 12'd7));
        put(32'h08, enc_r(7'h00, 5'd3, 3'b000, 5'd1, 5'd2));
        put(32'h0C, enc_s(5'd3, 5'd0, 12'h040));
        put(32'h10, enc_i(OP_L, 5'd4, 3'b010, 5'd0, 12'h040));
        put(32'h14, enc_s(5'd4, 5'd0, 12'h044));
        put(32'h18, enc_b(5'd0, 5'd0, 13'h0));
        exp_q.push_back({32'h40, 32'd12});
        exp_q.push_back({32'h44, 32'd12});
        check("rst_memreq", {31'b0, MemReq}, 32'd0);
        check("rst_memwrite", {31'b0, MemWrite}, 32'd0);
        check("rst_trap", {31'b0, Trap}, 32'd0);
        check("rst_state", {28'b0, dbg_state}, 32'd0);
        release_reset();
        @(negedge clk);
        check("req_before_edge", {31'b0, MemReq}, 32'd0);
        @(negedge clk);
        check("first_req", {31'b0, MemReq}, 32'd1);
        check("first_adr", Adr, 32'h0);
        wait_fetches(7, 300);
        if (fa_q.size() >= 7) begin
            check("cyc_3_instr", 32'(fc_q[3] - fc_q[0]), 32'd12);
            check("cyc_sw_wait3", 32'(fc_q[4] - fc_q[3]), 32'd7);
            check("cyc_lw_wait3", 32'(fc_q[5] - fc_q[4]), 32'd8);
            check("fetch_adr_6", fa_q[6], 32'h18);
        end
        check("sw_held_cycles", 32'(held40), 32'd4);
        check("stores_left_a", 32'(exp_q.size()), 32'd0);

        // Run B1: taken beq backwards.
        start_run();
        fetch_wait = 0; data_wait = 0; idle_ready = 1'b1;
        put(32'h00, enc_i(OP_I, 5'd1, 3'b000, 5'd0, 12'd1));
        put(32'h04, enc_i(OP_I, 5'd2, 3'b000, 5'd0, 12'd2));
        put(32'h08, enc_i(OP_I, 5'd0, 3'b000, 5'd0, 12'd0));
        put(32'h0C, enc_i(OP_I, 5'd0, 3'b000, 5'd0, 12'd0));
        put(32'h10, enc_b(5'd1, 5'd1, 13'h1FF8));
        release_reset();
        wait_fetches(7, 200);
        if (fa_q.size() >= 7) begin
            check("beq_taken_adr", fa_q[5], 32'h08);
            check("beq_cycles", 32'(fc_q[5] - fc_q[4]), 32'd3);
            check("after_beq_adr", fa_q[6], 32'h0C);
        end

        // Run B2: untaken beq, jal, x0, slt/slti, sub, logic ops, wrap.
        start_run();
        fetch_wait = 2; data_wait = 1; idle_ready = 1'b0;
        put(32'h00, enc_i(OP_I, 5'd1, 3'b000, 5'd0, 12'd1));
        put(32'h04, enc_i(OP_I, 5'd2, 3'b000, 5'd0, 12'd2));
        for (int i = 2; i < 8; i++) put(32'(i * 4), enc_i(OP_I, 5'd0, 3'b000, 5'd0, 12'd0));
        put(32'h10, enc_b(5'd1, 5'd2, 13'h1FF8));
        put(32'h20, enc_j(5'd5, 21'h100));
        put(32'h120, enc_s(5'd5, 5'd0, 12'h080));
        put(32'h124, enc_i(OP_I, 5'd0, 3'b000, 5'd0, 12'd9));
        put(32'h128, enc_s(5'd0, 5'd0, 12'h084));
        put(32'h12C, enc_i(OP_I, 5'd6, 3'b010, 5'd0, 12'hFFF));
        put(32'h130, enc_s(5'd6, 5'd0, 12'h088));
        put(32'h134, enc_i(OP_L, 5'd7, 3'b010, 5'd0, 12'h090));
        put(32'h138, enc_r(7'h00, 5'd8, 3'b010, 5'd7, 5'd1));
        put(32'h13C, enc_s(5'd8, 5'd0, 12'h08C));
        put(32'h140, enc_r(7'h20, 5'd9, 3'b000, 5'd0, 5'd1));
        put(32'h144, enc_s(5'd9, 5'd0, 12'h098));
        put(32'h148, enc_r(7'h00, 5'd10, 3'b111, 5'd9, 5'd7));
        put(32'h14C, enc_s(5'd10, 5'd0, 12'h09C));
        put(32'h150, enc_i(OP_I, 5'd11, 3'b110, 5'd7, 12'h0F0));
        put(32'h154, enc_i(OP_I, 5'd12, 3'b111, 5'd11, 12'h0FF));
        put(32'h158, enc_s(5'd12, 5'd0, 12'h0A0));
        put(32'h15C, enc_r(7'h00, 5'd13, 3'b110, 5'd1, 5'd2));
        put(32'h160, enc_s(5'd13, 5'd0, 12'h0A4));
        put(32'h164, enc_r(7'h00, 5'd14, 3'b000, 5'd9, 5'd1));
        put(32'h168, enc_s(5'd14, 5'd0, 12'h0A8));
        put(32'h16C, enc_b(5'd0, 5'd0, 13'h0));
        put(32'h090, 32'h8000_0000);
        exp_q.push_back({32'h80, 32'h24});
        exp_q.push_back({32'h84, 32'h0});
        exp_q.push_back({32'h88, 32'h0});
        exp_q.push_back({32'h8C, 32'h1});
        exp_q.push_back({32'h98, 32'hFFFF_FFFF});
        exp_q.push_back({32'h9C, 32'h8000_0000});
        exp_q.push_back({32'hA0, 32'hF0});
        exp_q.push_back({32'hA4, 32'h3});
        exp_q.push_back({32'hA8, 32'h0});
        release_reset();
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("stores_left_b", 32'(exp_q.size()), 32'd0);
        if (fa_q.size() >= 10) begin
            check("beq_not_taken_adr", fa_q[5], 32'h14);
            check("beq_nt_cycles_w2", 32'(fc_q[5] - fc_q[4]), 32'd5);
            check("jal_target_adr", fa_q[9], 32'h120);
        end else begin
            check("fetch_trace_b", 32'(fa_q.size()), 32'd10);
        end

        // Run C: illegal opcode trap, reset out of trap, reset mid-fetch.
        start_run();
        fetch_wait = 0; data_wait = 0; idle_ready = 1'b1;
        put(32'h00, 32'h0000_007F);
        release_reset();
        k = 0;
        while (dbg_state != 4'd1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("reach_decode", {28'b0, dbg_state}, 32'd1);
        @(negedge clk);
        check("trap_set", {31'b0, Trap}, 32'd1);
        reqs = 0;
        repeat (20) begin
            @(negedge clk);
            if (MemReq) reqs++;
        end
        check("trap_no_req", 32'(reqs), 32'd0);
        check("trap_sticky", {31'b0, Trap}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("trap_cleared", {31'b0, Trap}, 32'd0);
        check("state_after_rst", {28'b0, dbg_state}, 32'd0);
        put(32'h00, enc_i(OP_I, 5'd1, 3'b000, 5'd0, 12'd5));
        fetch_wait = 5;
        repeat (2) @(negedge clk);
        fa_q.delete();
        release_reset();
        k = 0;
        while (!MemReq && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("stalled_fetch_req", {31'b0, MemReq}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("req_drop_on_rst", {31'b0, MemReq}, 32'd0);
        check("no_fetch_commit", 32'(fa_q.size()), 32'd0);
        fetch_wait = 0;
        repeat (2) @(negedge clk);
        release_reset();
        wait_fetches(1, 50);
        if (fa_q.size() >= 1) check("refetch_reset_pc", fa_q[0], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
